motor_pwm_contr: RTL and testbench
==================================

# motor_pwm_contr

- Parametrised successor of the on/off motor command block for the two-motor drive.
- Maps the four direction commands (`frente`, `tras`, `direita`, `esquerda`) onto the same 4-bit H-bridge pattern, then adds the following:
  - PWM speed control with a programmable duty ceiling.
  - A soft-start duty ramp.
  - A mandatory all-off dead time on every pattern change.
- Sits between the command decoder and the H-bridge driver pins.

## Interface
Parameters:
- `PWM_BITS`, 8 — duty/PWM counter width; PWM period = 2^PWM_BITS ticks.
- `PRESCALE`, 4 — clk cycles per PWM tick; ≥1.
- `DEADTIME`, 16 — clk cycles of all-off between patterns; ≥1.
- `RAMP_STEP`, 8 — duty increment per PWM period; 1..2^PWM_BITS-1.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `frente` in 1 — forward command.
- `tras` in 1 — reverse command.
- `direita` in 1 — turn-right command.
- `esquerda` in 1 — turn-left command.
- `duty_max` in PWM_BITS — duty ceiling; sampled at period boundaries only.
- `motores` out 4 — bridge drive; bits[1:0] = motor A {rev,fwd}, bits[3:2] = motor B {rev,fwd}.
- `estado` out 2 — FSM state (PARADO=0, ACIONA=1, MORTO=2).
- `duty_atual` out PWM_BITS — duty currently applied.

## Operation
- **Command decode** — fixed priority `esquerda` > `direita` > `tras` > `frente`:
  - `esquerda` = 4'b0001, `direita` = 4'b0100, `tras` = 4'b1010, `frente` = 4'b0101.
  - No command = 4'b0000.
  - The decoded pattern is registered into `cmd_r` every cycle.
- **PWM generator**:
  - Prescaler counts 0..PRESCALE-1 and emits `tick` on PRESCALE-1.
  - `pwm_cnt` increments on `tick` and wraps 2^PWM_BITS-1→0.
  - `fim_periodo` = `tick` && `pwm_cnt` == all-ones.
  - `pwm_on` = `pwm_cnt` < `duty_atual`, so duty all-ones gives (2^W-1)/2^W on-time and 0 gives fully off.
  - The generator is free-running and never reset by the FSM.
- **FSM**:
  - PARADO:
    - `duty_atual`=0, `pat_r`=0.
    - `cmd_r`≠0 → ACIONA, `pat_r`←`cmd_r`, `duty_atual`←0.
  - ACIONA:
    - `cmd_r`=0 → PARADO immediately, with no dead time.
    - `cmd_r`≠0 and ≠`pat_r` → MORTO, `dead_cnt`←DEADTIME-1, `duty_atual`←0.
    - Otherwise on `fim_periodo`: `duty_atual` ← min(`duty_atual`+RAMP_STEP, `duty_max`). The sum is computed PWM_BITS+1 wide and saturates. If `duty_max` < `duty_atual`, it drops to `duty_max`.
  - MORTO:
    - `dead_cnt` decrements each clk.
    - At 0: `cmd_r`=0 → PARADO; else → ACIONA with `pat_r`←`cmd_r`, `duty_atual`←0.
    - A command change during MORTO does not restart the count.
- **Output** — `motores` ← (`estado`==ACIONA && `pwm_on`) ? `pat_r` : 0.
  - The output is registered.
  - A set fwd bit and rev bit on the same motor is impossible by construction.
- **Reset values** — `motores`=0, `estado`=PARADO, `duty_atual`=0, prescaler/`pwm_cnt`/`dead_cnt`/`cmd_r`/`pat_r`=0.
  - Reset mid-ACIONA or mid-MORTO forces these values on the next edge.

## Timing
- Command latency: input change at edge k → `cmd_r` updates at edge k → `estado` updates at edge k+1 → `motores` reflects the change at edge k+2.
- Stop: `motores`=0 no later than edge k+2 after all commands drop.
- Pattern change: `motores`=0 for at least DEADTIME+1 cycles between the last cycle of the old pattern and the first cycle of the new one.
- Ramp:
  - Duty rises by RAMP_STEP at each `fim_periodo` edge.
  - Full ceiling D is reached after ceil(D/RAMP_STEP) period boundaries.
  - `duty_max` changes take effect only at `fim_periodo`, giving glitch-free PWM.
- First ACIONA period after entry runs at duty 0 until the next boundary.

## Structure
- Package `motor_pkg`: state encoding PARADO/ACIONA/MORTO and pattern constants PAT_FRENTE, PAT_TRAS, PAT_DIREITA, PAT_ESQUERDA, PAT_PARADO.
- Sub-module `pwm_gerador` (parameters PWM_BITS, PRESCALE):
  - Contains the prescaler, `pwm_cnt` and comparator.
  - Inputs: `clk`, `reset`, `duty_atual`.
  - Outputs: `pwm_on`, `fim_periodo`.
- FSM, decode and ramp logic stay in the top level.

## Test plan
Bench parameters: PWM_BITS=4, PRESCALE=2, DEADTIME=5, RAMP_STEP=4, `duty_max`=12. Period = 32 clk.

1. Reset, no commands → `motores`=0, `estado`=0, `duty_atual`=0 for 200 cycles.
2. Assert `frente`:
   - `estado`=1 two edges later.
   - `duty_atual` steps 4, 8, 12 at successive `fim_periodo` edges, then holds 12.
   - `motores`=0101 for 12 of every 16 ticks, 0 otherwise.
3. `frente` at duty 12, switch to `tras` → `estado`=2, `motores`=0 for ≥6 cycles, then `estado`=1, pattern 1010, `duty_atual` restarts at 0.
4. `frente` and `esquerda` together → pattern 0001. Drop both → `motores`=0 by edge k+2, `estado`=0, no MORTO.
5. Lower `duty_max` to 4 mid-run at duty 12 → `duty_atual`=4 at next `fim_periodo`, not before.
6. Assert `reset` during MORTO with `dead_cnt`=3 → next edge all outputs at reset values. With `tras` held, ACIONA is re-entered two edges after `reset` releases.

Source files
------------

// File: rtl/motor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_pkg                                                          |
// | State encoding, H-bridge patterns and command decode for the       |
// | two-motor PWM controller.                                          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package motor_pkg;

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        ACIONA = 2'd1,
        MORTO  = 2'd2
    } estado_t;

    // bits[1:0] = motor A {rev,fwd}, bits[3:2] = motor B {rev,fwd}
    localparam logic [3:0] PAT_PARADO   = 4'b0000;
    localparam logic [3:0] PAT_FRENTE   = 4'b0101;
    localparam logic [3:0] PAT_TRAS     = 4'b1010;
    localparam logic [3:0] PAT_DIREITA  = 4'b0100;
    localparam logic [3:0] PAT_ESQUERDA = 4'b0001;

    function automatic logic [3:0] decode_cmd(
        input logic frente,
        input logic tras,
        input logic direita,
        input logic esquerda
    );
        if (esquerda)
            return PAT_ESQUERDA;
        else if (direita)
            return PAT_DIREITA;
        else if (tras)
            return PAT_TRAS;
        else if (frente)
            return PAT_FRENTE;
        else
            return PAT_PARADO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_gerador.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_gerador                                                        |
// | Free-running prescaled PWM counter with duty comparator and        |
// | period-boundary strobe.                                            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwm_gerador #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty_atual,
    output logic                pwm_on,
    output logic                fim_periodo
);

    localparam int                 c_ps_bits   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_ps_bits-1:0] c_presc_last = c_ps_bits'(PRESCALE - 1);

    logic [c_ps_bits-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic                 w_tick;

    assign w_tick = (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end else begin
            r_presc   <= r_presc + c_ps_bits'(1);
        end
    end

    assign fim_periodo = w_tick && (r_pwm_cnt == '1);
    assign pwm_on      = (r_pwm_cnt < duty_atual);

endmodule
`default_nettype wire

// File: rtl/motor_pwm_contr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_pwm_contr                                                    |
// | Direction decode, soft-start PWM and dead-time sequencing for the  |
// | two-motor H-bridge.                                                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module motor_pwm_contr #(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 4,
    parameter int DEADTIME  = 16,
    parameter int RAMP_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frente,
    input  logic                tras,
    input  logic                direita,
    input  logic                esquerda,
    input  logic [PWM_BITS-1:0] duty_max,
    output logic [3:0]          motores,
    output logic [1:0]          estado,
    output logic [PWM_BITS-1:0] duty_atual
);

    import motor_pkg::*;

    localparam int                     c_dead_bits = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [c_dead_bits-1:0] c_dead_init = c_dead_bits'(DEADTIME - 1);
    localparam int                     c_sum_bits  = PWM_BITS + 1;
    localparam logic [c_sum_bits-1:0]  c_ramp_step = c_sum_bits'(RAMP_STEP);

    estado_t                r_estado, w_estado_nxt;
    logic [3:0]             r_cmd;
    logic [3:0]             r_pat, w_pat_nxt;
    logic [PWM_BITS-1:0]    r_duty, w_duty_nxt;
    logic [c_dead_bits-1:0] r_dead_cnt, w_dead_nxt;
    logic [3:0]             r_motores;
    logic                   w_pwm_on;
    logic                   w_fim;
    logic [c_sum_bits-1:0]  w_soma;
    logic [PWM_BITS-1:0]    w_rampa;

    pwm_gerador #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk         (clk),
        .reset       (reset),
        .duty_atual  (r_duty),
        .pwm_on      (w_pwm_on),
        .fim_periodo (w_fim)
    );

    // One bit of headroom so the ramp sum can saturate at the ceiling
    // instead of wrapping; a lowered ceiling also pulls the duty down.
    assign w_soma  = {1'b0, r_duty} + c_ramp_step;
    assign w_rampa = (w_soma > {1'b0, duty_max}) ? duty_max : w_soma[PWM_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= PARADO;
            r_cmd      <= PAT_PARADO;
            r_pat      <= PAT_PARADO;
            r_duty     <= '0;
            r_dead_cnt <= '0;
            r_motores  <= PAT_PARADO;
        end else begin
            r_estado   <= w_estado_nxt;
            r_cmd      <= decode_cmd(frente, tras, direita, esquerda);
            r_pat      <= w_pat_nxt;
            r_duty     <= w_duty_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_motores  <= ((r_estado == ACIONA) && w_pwm_on) ? r_pat : PAT_PARADO;
        end
    end

    always_comb begin
        w_estado_nxt = r_estado;
        w_pat_nxt    = r_pat;
        w_duty_nxt   = r_duty;
        w_dead_nxt   = r_dead_cnt;
        case (r_estado)
            PARADO: begin
                w_pat_nxt  = PAT_PARADO;
                w_duty_nxt = '0;
                if (r_cmd != PAT_PARADO) begin
                    w_estado_nxt = ACIONA;
                    w_pat_nxt    = r_cmd;
                end
            end
            ACIONA: begin
                if (r_cmd == PAT_PARADO) begin
                    w_estado_nxt = PARADO;
                    w_pat_nxt    = PAT_PARADO;
                    w_duty_nxt   = '0;
                end else if (r_cmd != r_pat) begin
                    w_estado_nxt = MORTO;
                    w_dead_nxt   = c_dead_init;
                    w_duty_nxt   = '0;
                end else if (w_fim) begin
                    w_duty_nxt   = w_rampa;
                end
            end
            MORTO: begin
                w_duty_nxt = '0;
                // Count is not restarted by command changes; the pattern is
                // resampled only once the bridge has been off long enough.
                if (r_dead_cnt == '0) begin
                    if (r_cmd == PAT_PARADO) begin
                        w_estado_nxt = PARADO;
                        w_pat_nxt    = PAT_PARADO;
                    end else begin
                        w_estado_nxt = ACIONA;
                        w_pat_nxt    = r_cmd;
                    end
                end else begin
                    w_dead_nxt = r_dead_cnt - c_dead_bits'(1);
                end
            end
            default: begin
                w_estado_nxt = PARADO;
                w_pat_nxt    = PAT_PARADO;
                w_duty_nxt   = '0;
            end
        endcase
    end

    assign motores    = r_motores;
    assign estado     = r_estado;
    assign duty_atual = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_contr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_motor_pwm_contr                                                 |
// | Directed scoreboard bench: expectations are queued against a cycle |
// | number and compared when that cycle is sampled.                    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_motor_pwm_contr;

    localparam int PWM_BITS  = 4;
    localparam int PRESCALE  = 2;
    localparam int DEADTIME  = 5;
    localparam int RAMP_STEP = 4;

    localparam int SEL_ESTADO = 0;
    localparam int SEL_DUTY   = 1;
    localparam int SEL_MOT    = 2;
    localparam int SEL_COUNT  = 3;

    logic                clk;
    logic                reset;
    logic                frente, tras, direita, esquerda;
    logic [PWM_BITS-1:0] duty_max;
    logic [3:0]          motores;
    logic [1:0]          estado;
    logic [PWM_BITS-1:0] duty_atual;

    motor_pwm_contr #(
        .PWM_BITS  (PWM_BITS),
        .PRESCALE  (PRESCALE),
        .DEADTIME  (DEADTIME),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frente     (frente),
        .tras       (tras),
        .direita    (direita),
        .esquerda   (esquerda),
        .duty_max   (duty_max),
        .motores    (motores),
        .estado     (estado),
        .duty_atual (duty_atual)
    );

    typedef struct {
        string      tag;
        int         cyc;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc;
    int         errors;
    int         checks;
    int         oncount;
    logic       count_en;
    logic [3:0] count_pat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since the last reset release; the DUT's PWM phase is tied to it.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic expect_at(input int c, input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        int   i;
        e.tag = tag;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, e);
    endtask

    task automatic check_due();
        exp_t       e;
        logic [7:0] obs;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_ESTADO: obs = {6'b0, estado};
                SEL_DUTY:   obs = {4'b0, duty_atual};
                SEL_MOT:    obs = {4'b0, motores};
                default:    obs = 8'(oncount);
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", e.tag, cyc, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (count_en && motores === count_pat) oncount++;
        check_due();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        oncount   = 0;
        count_en  = 1'b0;
        count_pat = 4'b0000;
        reset     = 1'b1;
        frente    = 1'b0;
        tras      = 1'b0;
        direita   = 1'b0;
        esquerda  = 1'b0;
        duty_max  = 4'd12;

        // Reset state, then idle for 200 cycles
        repeat (3) @(posedge clk);
        #1;
        expect_at(0, "rst_estado", SEL_ESTADO, 8'd0);
        expect_at(0, "rst_duty",   SEL_DUTY,   8'd0);
        expect_at(0, "rst_mot",    SEL_MOT,    8'd0);
        check_due();
        reset = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            expect_at(c, "idle_estado", SEL_ESTADO, 8'd0);
            expect_at(c, "idle_duty",   SEL_DUTY,   8'd0);
            expect_at(c, "idle_mot",    SEL_MOT,    8'd0);
        end
        run_until(200);

        // Forward: entry latency and soft-start ramp 4, 8, 12, hold
        frente = 1'b1;
        expect_at(201, "fwd_estado_k1",  SEL_ESTADO, 8'd0);
        expect_at(202, "fwd_estado_k2",  SEL_ESTADO, 8'd1);
        expect_at(202, "fwd_duty_entry", SEL_DUTY,   8'd0);
        expect_at(223, "fwd_duty_pre1",  SEL_DUTY,   8'd0);
        expect_at(224, "fwd_duty_4",     SEL_DUTY,   8'd4);
        expect_at(224, "fwd_mot_d0",     SEL_MOT,    8'h00);
        expect_at(225, "fwd_mot_d4_on",  SEL_MOT,    8'h05);
        expect_at(232, "fwd_mot_d4_end", SEL_MOT,    8'h05);
        expect_at(233, "fwd_mot_d4_off", SEL_MOT,    8'h00);
        expect_at(255, "fwd_duty_pre2",  SEL_DUTY,   8'd4);
        expect_at(256, "fwd_duty_8",     SEL_DUTY,   8'd8);
        expect_at(288, "fwd_duty_12",    SEL_DUTY,   8'd12);
        expect_at(320, "fwd_on_cycles",  SEL_COUNT,  8'd24);
        expect_at(320, "fwd_duty_hold",  SEL_DUTY,   8'd12);
        expect_at(321, "fwd_mot_on0",    SEL_MOT,    8'h05);
        expect_at(344, "fwd_mot_on23",   SEL_MOT,    8'h05);
        expect_at(345, "fwd_mot_off24",  SEL_MOT,    8'h00);
        expect_at(353, "fwd_mot_wrap",   SEL_MOT,    8'h05);
        run_until(288);
        oncount   = 0;
        count_pat = 4'b0101;
        count_en  = 1'b1;
        run_until(320);
        count_en  = 1'b0;

        // Forward -> reverse through dead time
        run_until(360);
        frente = 1'b0;
        tras   = 1'b1;
        expect_at(361, "sw_estado_k1",   SEL_ESTADO, 8'd1);
        expect_at(361, "sw_mot_old1",    SEL_MOT,    8'h05);
        expect_at(362, "sw_estado_morto",SEL_ESTADO, 8'd2);
        expect_at(362, "sw_mot_old2",    SEL_MOT,    8'h05);
        expect_at(362, "sw_duty_zero",   SEL_DUTY,   8'd0);
        expect_at(366, "sw_estado_morto_end", SEL_ESTADO, 8'd2);
        expect_at(367, "sw_estado_aciona", SEL_ESTADO, 8'd1);
        expect_at(367, "sw_duty_restart", SEL_DUTY,  8'd0);
        expect_at(384, "sw_off_cycles",  SEL_COUNT,  8'd22);
        expect_at(384, "sw_duty_4",      SEL_DUTY,   8'd4);
        expect_at(385, "sw_mot_new",     SEL_MOT,    8'h0A);
        expect_at(416, "sw_duty_8",      SEL_DUTY,   8'd8);
        expect_at(448, "sw_duty_12",     SEL_DUTY,   8'd12);
        run_until(362);
        oncount   = 0;
        count_pat = 4'b0000;
        count_en  = 1'b1;
        run_until(384);
        count_en  = 1'b0;

        // Ceiling lowered mid-period applies only at the boundary
        run_until(460);
        duty_max = 4'd4;
        expect_at(479, "cap_duty_before", SEL_DUTY, 8'd12);
        expect_at(480, "cap_duty_after",  SEL_DUTY, 8'd4);
        expect_at(481, "cap_mot_on",      SEL_MOT,  8'h0A);
        expect_at(488, "cap_mot_last",    SEL_MOT,  8'h0A);
        expect_at(489, "cap_mot_off",     SEL_MOT,  8'h00);
        run_until(490);
        duty_max = 4'd12;

        // Stop without dead time
        run_until(500);
        tras = 1'b0;
        expect_at(501, "stop_estado_k1", SEL_ESTADO, 8'd1);
        expect_at(502, "stop_estado_k2", SEL_ESTADO, 8'd0);
        expect_at(502, "stop_mot",       SEL_MOT,    8'h00);
        expect_at(502, "stop_duty",      SEL_DUTY,   8'd0);
        expect_at(503, "stop_no_morto",  SEL_ESTADO, 8'd0);

        // Priority: esquerda beats frente; then drop both
        run_until(520);
        frente   = 1'b1;
        esquerda = 1'b1;
        expect_at(521, "pri_estado_k1", SEL_ESTADO, 8'd0);
        expect_at(522, "pri_estado_k2", SEL_ESTADO, 8'd1);
        expect_at(544, "pri_duty_4",    SEL_DUTY,   8'd4);
        expect_at(545, "pri_mot_esq",   SEL_MOT,    8'h01);
        expect_at(551, "pri_estado_hold", SEL_ESTADO, 8'd1);
        expect_at(552, "drop_estado",   SEL_ESTADO, 8'd0);
        expect_at(552, "drop_mot_k1",   SEL_MOT,    8'h01);
        expect_at(552, "drop_duty",     SEL_DUTY,   8'd0);
        expect_at(553, "drop_mot_k2",   SEL_MOT,    8'h00);
        expect_at(553, "drop_no_morto", SEL_ESTADO, 8'd0);
        run_until(550);
        frente   = 1'b0;
        esquerda = 1'b0;

        // Reset in the middle of dead time
        run_until(600);
        frente = 1'b1;
        expect_at(602, "rm_estado_aciona", SEL_ESTADO, 8'd1);
        run_until(610);
        frente = 1'b0;
        tras   = 1'b1;
        expect_at(612, "rm_estado_morto1", SEL_ESTADO, 8'd2);
        expect_at(613, "rm_estado_morto2", SEL_ESTADO, 8'd2);
        run_until(613);
        reset = 1'b1;
        expect_at(0, "rm_rst_estado", SEL_ESTADO, 8'd0);
        expect_at(0, "rm_rst_duty",   SEL_DUTY,   8'd0);
        expect_at(0, "rm_rst_mot",    SEL_MOT,    8'h00);
        step();
        reset = 1'b0;
        expect_at(1, "rm_rel_estado_k1", SEL_ESTADO, 8'd0);
        expect_at(2, "rm_rel_estado_k2", SEL_ESTADO, 8'd1);
        expect_at(2, "rm_rel_duty",      SEL_DUTY,   8'd0);
        run_until(2);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d pending expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
